// File: rtl/day2_pkg.sv
// Shared state encodings and ASCII constants for the day2 range parser.
package day2_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_START = 3'd0;
  localparam state_t S_END   = 3'd1;
  localparam state_t S_LOAD  = 3'd2;
  localparam state_t S_RUN   = 3'd3;
  localparam state_t S_ERR   = 3'd4;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;

endpackage

// File: rtl/day2_range_parser_if.sv
// Byte-stream handshake carrying the ASCII puzzle input into the parser.
interface day2_range_parser_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/day2_dec_accum.sv
// Decimal field accumulator: value = value*10 + digit, with overflow and digit-count limits.
module day2_dec_accum #(
  parameter int W          = 48,
  parameter int MAX_DIGITS = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         digit_strobe,
  input  logic [3:0]   digit,
  input  logic         clear,
  output logic [W-1:0] value,
  output logic [W-1:0] value_next,
  output logic         ovf,
  output logic         has_digit
);

  localparam int XW = W + 4;

  logic [4:0]    digit_count;
  logic [XW-1:0] product;

  // Four guard bits catch any result above 2^W-1 before it is committed.
  assign product    = {4'b0000, value} * XW'(10) + XW'(digit);
  assign value_next = product[W-1:0];
  assign ovf        = (product[XW-1:W] != 4'd0) || (digit_count == 5'(MAX_DIGITS));
  assign has_digit  = (digit_count != 5'd0);

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      value       <= '0;
      digit_count <= '0;
    end else if (digit_strobe && !ovf) begin
      value       <= value_next;
      digit_count <= digit_count + 5'd1;
    end
  end

endmodule

// File: rtl/day2_range_parser.sv
// Parses "a-b,c-d,...\n" into start_id/end_id slot arrays, then pulses load and holds en.
module day2_range_parser
  import day2_pkg::*;
#(
  parameter  int W         = 48,
  parameter  int NUM_UNITS = 38,
  localparam int CNT_W     = $clog2(NUM_UNITS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  day2_range_parser_if.slave stream,
  output logic [W-1:0]       start_id [NUM_UNITS],
  output logic [W-1:0]       end_id   [NUM_UNITS],
  output logic [CNT_W-1:0]   range_count,
  output logic               load,
  output logic               en,
  output logic               error
);

  state_t       state, nxt_state;
  logic [W-1:0] start_lat;
  logic [W-1:0] acc_value, acc_value_next, wr_val;
  logic         acc_ovf, acc_has_digit;
  logic         acc_strobe, acc_clear, latch_start, do_write, post_digits;
  logic         xfer, is_digit, is_dash, is_sep, is_ign;

  assign stream.in_ready = (state == S_START) || (state == S_END);
  assign xfer     = stream.in_valid && stream.in_ready;
  assign is_digit = (stream.in_data >= CH_0) && (stream.in_data <= CH_9);
  assign is_dash  = (stream.in_data == CH_DASH);
  assign is_sep   = (stream.in_data == CH_COMMA) || (stream.in_data == CH_LF);
  assign is_ign   = (stream.in_data == CH_CR) || (stream.in_data == CH_SP);

  assign load  = (state == S_LOAD);
  assign en    = (state == S_RUN);
  assign error = (state == S_ERR);

  day2_dec_accum #(.W(W)) u_accum (
    .clock        (clock),
    .reset        (reset),
    .digit_strobe (acc_strobe),
    .digit        (stream.in_data[3:0]),
    .clear        (acc_clear),
    .value        (acc_value),
    .value_next   (acc_value_next),
    .ovf          (acc_ovf),
    .has_digit    (acc_has_digit)
  );

  // The byte itself is decoded first; in_last then closes the stream on the post-byte state.
  always_comb begin
    nxt_state   = state;
    acc_strobe  = 1'b0;
    acc_clear   = 1'b0;
    latch_start = 1'b0;
    do_write    = 1'b0;
    wr_val      = acc_value;
    post_digits = acc_has_digit;
    if (xfer) begin
      if (is_digit) begin
        if (acc_ovf) begin
          nxt_state = S_ERR;
        end else begin
          acc_strobe  = 1'b1;
          post_digits = 1'b1;
          wr_val      = acc_value_next;
        end
      end else if (is_dash) begin
        if (state == S_START && acc_has_digit) begin
          latch_start = 1'b1;
          acc_clear   = 1'b1;
          post_digits = 1'b0;
          nxt_state   = S_END;
        end else begin
          nxt_state = S_ERR;
        end
      end else if (is_sep) begin
        if (state == S_END && acc_has_digit) begin
          do_write    = 1'b1;
          acc_clear   = 1'b1;
          post_digits = 1'b0;
          nxt_state   = S_START;
        end else if (state == S_END || acc_has_digit) begin
          nxt_state = S_ERR;
        end
      end else if (!is_ign) begin
        nxt_state = S_ERR;
      end

      if (stream.in_last && nxt_state != S_ERR) begin
        if (nxt_state == S_END && post_digits) begin
          do_write  = 1'b1;
          acc_clear = 1'b1;
          nxt_state = S_LOAD;
        end else if (nxt_state == S_START && !post_digits) begin
          nxt_state = S_LOAD;
        end else begin
          nxt_state = S_ERR;
        end
      end

      if (do_write && range_count == CNT_W'(NUM_UNITS)) begin
        do_write  = 1'b0;
        nxt_state = S_ERR;
      end
    end else if (state == S_LOAD) begin
      nxt_state = S_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_START;
      start_lat   <= '0;
      range_count <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        start_id[i] <= '0;
        end_id[i]   <= '0;
      end
    end else begin
      state <= nxt_state;
      if (latch_start) start_lat <= acc_value;
      if (do_write) range_count <= range_count + CNT_W'(1);
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (do_write && range_count == CNT_W'(i)) begin
          start_id[i] <= start_lat;
          end_id[i]   <= wr_val;
        end
      end
    end
  end

endmodule
